pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control block for the 5-stage datapath (IF, ID, EX, MEM, WB). It tracks the occupancy and metadata of each in-flight instruction and generates load-use and interlock stalls, wrong-path squash on MEM-stage redirect, and forwarding selects. It also counts retired instructions and provides halt detection. It replaces the datapath's hard-wired readM1=1 and combinational num_inst logic, and sits beside the IF_ID/ID_EX/EX_MEM/MEM_WB registers, driving their enables and bubbles.

Parameters:
WORD_SIZE, 16, width of num_inst and stall_cnt counters
REG_W, 2, register-specifier width
FWD_EN, 1, 1 = full forwarding (stall only on load-use); 0 = interlock mode (stall on any EX/MEM RAW)

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs, id_rt  in  REG_W  ID source specifiers
id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt
id_rd  in  REG_W  ID destination
id_reg_write, id_is_load, id_is_halt, id_is_wwd  in  1  ID decode flags
flush_i  in  1  MEM-stage taken branch/jump redirect this cycle
stall_o  out  1  hold PC and IF/ID; insert bubble into ID/EX
if_id_flush_o  out  1  squash IF/ID contents
ex_valid_o  out  1  EX slot holds a real instruction
fwd_a_o, fwd_b_o  out  2  EX operand select: 0 = ID/EX regfile value, 1 = EX/MEM ALU result, 2 = MEM/WB w_data
id_byp_a_o, id_byp_b_o  out  1  ID read bypass from WB w_data (same-cycle write)
wb_retire_o, wb_wwd_o  out  1  WB slot retiring / retiring a WWD
num_inst  out  WORD_SIZE  retired-instruction count
stall_cnt  out  WORD_SIZE  stall cycles inserted
is_halted  out  1  sticky halt

Behaviour:
- Slots EX, MEM, and WB are each registered as {valid, rd, we, is_load, is_halt, is_wwd}. Match(slot, r) = slot.valid & slot.we & slot.rd==r.
- Reset (async): all slot valid bits 0, fwd_* = 0, num_inst = 0, stall_cnt = 0, is_halted = 0. All combinational outputs are then 0.
- halt_pending = valid & is_halt in any of EX, MEM, WB.
- Hazard, ID source r with use bit set:
  - FWD_EN=1: hazard if Match(EX, r) & EX.is_load.
  - FWD_EN=0: hazard if Match(EX, r) | Match(MEM, r).
- stall_o = id_valid & (hazard on rs | hazard on rt | halt_pending | is_halted) & ~flush_i. Flush has priority over stall.
- if_id_flush_o = flush_i (combinational).
- Issue = id_valid & ~stall_o & ~flush_i & ~is_halted.
- Posedge update:
  - EX <= Issue ? ID fields : bubble.
  - MEM <= flush_i ? bubble : EX.
  - WB <= MEM.
  - The instruction in MEM that asserts flush_i is not squashed; only younger instructions are.
- Forwarding selects are computed at ID and registered into fwd_* with the issue, so they are valid during that instruction's EX cycle. Per source:
  - sel = 1 if Match(EX, r) & ~EX.is_load & FWD_EN.
  - else sel = 2 if Match(MEM, r) & FWD_EN.
  - else sel = 0.
  - Youngest producer wins. When no issue, fwd_* <= 0.
- id_byp_a_o = id_use_rs & Match(WB, id_rs); id_byp_b_o likewise for rt. Active in both modes.
- wb_retire_o = WB.valid & ~is_halted. wb_wwd_o = wb_retire_o & WB.is_wwd.
- num_inst += 1 on each cycle with wb_retire_o. Wraps modulo 2^WORD_SIZE.
- stall_cnt += 1 on each cycle with stall_o & ~is_halted. Wraps.
- is_halted sets the cycle after WB.valid & WB.is_halt (the halt itself is counted) and holds until reset. Once halted, no further issue or count, and slots drain to invalid.
- A halt in EX/MEM squashed by flush_i clears halt_pending, and issue resumes the next cycle.
- Reset asserted mid-operation: all slots immediately invalid; no partial counts retained.

Test Plan:
1. Reset, then 5 independent ALU ops (id_valid=1, no matching rd) -> stall_o never 1, fwd = 0, num_inst = 5 four cycles after the last issue, stall_cnt = 0.
2. FWD_EN=1: ADD rd=1, then ADD rs=1 next cycle -> no stall, fwd_a_o = 1 in EX; with one independent op between -> fwd_a_o = 2; with two between -> id_byp_a_o = 1 in ID.
3. FWD_EN=1: LWD rd=2, then ADD rt=2 -> stall_o = 1 for exactly 1 cycle, bubble in EX, then fwd_b_o = 2, stall_cnt = 1.
4. FWD_EN=0: ADD rd=3, then use of r3 -> stall_o = 1 for 2 cycles, then id_byp = 1, fwd = 0, stall_cnt = 2.
5. flush_i pulsed while a halt sits in EX and a stall is pending -> stall_o = 0, EX and MEM next bubbles, halt never retires, num_inst excludes the 2 squashed ops.
6. HLT retires with num_inst = 7 -> is_halted = 1 next cycle, num_inst stays 7 and stall_cnt frozen over 10 more cycles; async reset_n low mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage datapath: tracks EX/MEM/WB occupancy,
// generates stalls, wrong-path squash, forwarding selects, retire/stall counters and halt.
module pipe_hazard_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int REG_W     = 2,
    parameter bit FWD_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic [REG_W-1:0]     id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_is_load,
    input  logic                 id_is_halt,
    input  logic                 id_is_wwd,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 if_id_flush_o,
    output logic                 ex_valid_o,
    output logic [1:0]           fwd_a_o,
    output logic [1:0]           fwd_b_o,
    output logic                 id_byp_a_o,
    output logic                 id_byp_b_o,
    output logic                 wb_retire_o,
    output logic                 wb_wwd_o,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [WORD_SIZE-1:0] stall_cnt,
    output logic                 is_halted
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
        logic             is_halt;
        logic             is_wwd;
    } slot_t;

    slot_t ex_q;
    slot_t mem_q;
    slot_t id_slot;

    // WB only needs the fields that retire, bypass or halt consume.
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             wb_we;
    logic             wb_is_halt;
    logic             wb_is_wwd;

    logic       haz_rs;
    logic       haz_rt;
    logic       halt_pending;
    logic       issue;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    function automatic logic match(input logic v, input logic we,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] r);
        return v & we & (rd == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input logic [REG_W-1:0] r);
        logic [1:0] sel;
        sel = 2'd0;
        if (FWD_EN) begin
            if (match(ex_s.valid, ex_s.we, ex_s.rd, r) && !ex_s.is_load) begin
                sel = 2'd1;
            end else if (match(mem_s.valid, mem_s.we, mem_s.rd, r)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        id_slot.valid   = 1'b1;
        id_slot.rd      = id_rd;
        id_slot.we      = id_reg_write;
        id_slot.is_load = id_is_load;
        id_slot.is_halt = id_is_halt;
        id_slot.is_wwd  = id_is_wwd;
    end

    // With full forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        if (FWD_EN) begin
            haz_rs = id_use_rs & match(ex_q.valid, ex_q.we, ex_q.rd, id_rs) & ex_q.is_load;
            haz_rt = id_use_rt & match(ex_q.valid, ex_q.we, ex_q.rd, id_rt) & ex_q.is_load;
        end else begin
            haz_rs = id_use_rs & (match(ex_q.valid, ex_q.we, ex_q.rd, id_rs) |
                                  match(mem_q.valid, mem_q.we, mem_q.rd, id_rs));
            haz_rt = id_use_rt & (match(ex_q.valid, ex_q.we, ex_q.rd, id_rt) |
                                  match(mem_q.valid, mem_q.we, mem_q.rd, id_rt));
        end
    end

    assign halt_pending = (ex_q.valid & ex_q.is_halt) |
                          (mem_q.valid & mem_q.is_halt) |
                          (wb_valid & wb_is_halt);

    // A redirect overrides any stall: the ID instruction is wrong-path anyway.
    assign stall_o       = id_valid & (haz_rs | haz_rt | halt_pending | is_halted) & ~flush_i;
    assign if_id_flush_o = flush_i;
    assign issue         = id_valid & ~stall_o & ~flush_i & ~is_halted;

    assign sel_a = fwd_sel(ex_q, mem_q, id_rs);
    assign sel_b = fwd_sel(ex_q, mem_q, id_rt);

    assign ex_valid_o  = ex_q.valid;
    assign id_byp_a_o  = id_use_rs & match(wb_valid, wb_we, wb_rd, id_rs);
    assign id_byp_b_o  = id_use_rt & match(wb_valid, wb_we, wb_rd, id_rt);
    assign wb_retire_o = wb_valid & ~is_halted;
    assign wb_wwd_o    = wb_retire_o & wb_is_wwd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_we      <= 1'b0;
            wb_is_halt <= 1'b0;
            wb_is_wwd  <= 1'b0;
            fwd_a_o    <= 2'd0;
            fwd_b_o    <= 2'd0;
        end else begin
            ex_q  <= issue ? id_slot : '0;
            // The redirecting instruction itself sits in MEM and moves on to WB.
            mem_q      <= flush_i ? '0 : ex_q;
            wb_valid   <= mem_q.valid;
            wb_rd      <= mem_q.rd;
            wb_we      <= mem_q.we;
            wb_is_halt <= mem_q.is_halt;
            wb_is_wwd  <= mem_q.is_wwd;
            fwd_a_o    <= issue ? sel_a : 2'd0;
            fwd_b_o    <= issue ? sel_b : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst  <= '0;
            stall_cnt <= '0;
            is_halted <= 1'b0;
        end else begin
            if (wb_retire_o) begin
                num_inst <= num_inst + WORD_SIZE'(1);
            end
            if (stall_o && !is_halted) begin
                stall_cnt <= stall_cnt + WORD_SIZE'(1);
            end
            if (wb_valid && wb_is_halt) begin
                is_halted <= 1'b1;
            end
        end
    end

endmodule
